mfp_ahb_sprite_table_ram_db: RTL

- Parametrised, double-buffered successor to the AHB-Lite sprite table RAM.
- The AHB side reads and writes the back bank. The video engine reads the front bank through a dedicated 1-cycle read port.
- Banks swap only on a vsync rising edge after software requests it, so tear-free sprite updates need no CPU timing.
- Sits on the AHB-Lite slave mux alongside the other video RAMs.

---
 rtl/mfp_ahb_sprite_table_ram_db.sv | 104 ++++++++++
 1 files changed

// File: rtl/mfp_ahb_sprite_table_ram_db.sv
// mfp_ahb_sprite_table_ram_db: double-buffered AHB-Lite sprite table RAM with a registered front-bank video read port
module mfp_ahb_sprite_table_ram_db #(
    parameter int ADDR_WIDTH = 6,
    parameter bit DOUBLE_BUF = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [31:0]           HADDR,
    input  logic [2:0]            HBURST,
    input  logic                  HMASTLOCK,
    input  logic [3:0]            HPROT,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           HWDATA,
    input  logic                  HWRITE,
    input  logic                  HSEL,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    input  logic                  vsync,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [31:0]           vid_data
);
    localparam int AW = ADDR_WIDTH;

    logic [31:0]   mem [2**(AW+1)];
    logic          dp_valid_q, dp_valid_d, dp_write_q, dp_write_d, dp_ctrl_q, dp_ctrl_d;
    logic          dp_bank_q, dp_bank_d;
    logic [AW-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]    dp_mask_q, dp_mask_d;
    logic          stall_q, stall_d, front_q, front_d, pend_q, pend_d, vsync_q;
    logic [31:0]   rd_q, rd_d, vid_q, vid_d;
    logic          accept, ctrl_sel, back, wr_en, set_req, swap_edge, hazard;
    logic [AW-1:0] addr;
    logic [3:0]    mask;
    logic          unused;

    assign unused = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0], HADDR[31:AW+3]};

    always_comb begin
        accept     = HSEL & HREADY & HTRANS[1];
        ctrl_sel   = HADDR[AW+2];
        addr       = HADDR[AW+1:2];
        back       = DOUBLE_BUF ? ~front_q : 1'b0;
        mask       = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wr_en      = dp_valid_q & dp_write_q & ~dp_ctrl_q;
        set_req    = dp_valid_q & dp_write_q & dp_ctrl_q & (dp_addr_q == '0) & HWDATA[0];
        swap_edge  = DOUBLE_BUF ? vsync & ~vsync_q : 1'b1;
        // The read would sample the word one edge before the in-flight write lands
        hazard     = accept & ~ctrl_sel & ~HWRITE & wr_en & (dp_bank_q == back) & (dp_addr_q == addr);
        dp_valid_d = HREADY ? accept : dp_valid_q;
        dp_write_d = HREADY ? HWRITE : dp_write_q;
        dp_ctrl_d  = HREADY ? ctrl_sel : dp_ctrl_q;
        dp_bank_d  = HREADY ? back : dp_bank_q;
        dp_addr_d  = HREADY ? addr : dp_addr_q;
        dp_mask_d  = HREADY ? mask : dp_mask_q;
        stall_d    = hazard;
        rd_d       = stall_q ? mem[{dp_bank_q, dp_addr_q}] : ~accept ? rd_q :
                     ctrl_sel ? {30'd0, front_q, pend_q} & {32{addr == '0}} : mem[{back, addr}];
        vid_d      = mem[{front_q, vid_addr}];
        pend_d     = pend_q ? ~swap_edge : set_req;
        front_d    = DOUBLE_BUF ? front_q ^ (pend_q & swap_edge) : 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_ctrl_q  <= 1'b0;
            dp_bank_q  <= 1'b0;
            dp_addr_q  <= '0;
            dp_mask_q  <= '0;
            stall_q    <= 1'b0;
            rd_q       <= '0;
            vid_q      <= '0;
            front_q    <= 1'b0;
            pend_q     <= 1'b0;
            vsync_q    <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_ctrl_q  <= dp_ctrl_d;
            dp_bank_q  <= dp_bank_d;
            dp_addr_q  <= dp_addr_d;
            dp_mask_q  <= dp_mask_d;
            stall_q    <= stall_d;
            rd_q       <= rd_d;
            vid_q      <= vid_d;
            front_q    <= front_d;
            pend_q     <= pend_d;
            vsync_q    <= vsync;
        end
    end

    always_ff @(posedge HCLK)
        for (int i = 0; i < 4; i++)
            if (wr_en && !HRESET && dp_mask_q[i]) mem[{dp_bank_q, dp_addr_q}][8*i +: 8] <= HWDATA[8*i +: 8];

    assign HRDATA    = rd_q;
    assign HREADYOUT = ~stall_q;
    assign HRESP     = 1'b0;
    assign vid_data  = vid_q;
endmodule
